// File: rtl/gba_io_pkg.sv
// Shared definitions for the GBA cart / USB memory-port arbiter.
// Width codes, arbiter state and source encodings, cart data lane helpers.
package gba_io_pkg;

  localparam int unsigned ADDR_W = 26;

  localparam logic [1:0] W8  = 2'b01;
  localparam logic [1:0] W16 = 2'b10;
  localparam logic [1:0] W32 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_CART,
    SRC_USB
  } src_t;

  // Cart writes are zero-extended into the 32-bit memory write word.
  function automatic logic [31:0] cart_wr_word(input logic [1:0] width, input logic [15:0] data);
    return (width == W8) ? {24'h0, data[7:0]} : {16'h0, data};
  endfunction

  function automatic logic [15:0] cart_rd_half(input logic [1:0] width, input logic [15:0] data);
    return (width == W8) ? {8'h0, data[7:0]} : data;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_cart_req_capture.sv
// One-deep pending register for single-cycle cart strobes, with sticky
// overrun detection for strobes that cannot be accepted.
module cart_req_capture
  import gba_io_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_width,
  input  logic [15:0]       i_wdata,
  input  logic              i_retire,
  output logic              o_pending,
  output logic              o_op_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_width,
  output logic [15:0]       o_wdata,
  output logic              o_overrun
);

  logic              r_pending;
  logic              r_op_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_width;
  logic [15:0]       r_wdata;
  logic              r_overrun;
  logic              w_strobe;
  logic              w_busy;

  // The slot is free if empty or retiring this cycle.
  always_comb begin
    w_strobe = i_rd | i_wr;
    w_busy   = r_pending & ~i_retire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_op_wr   <= 1'b0;
      r_addr    <= '0;
      r_width   <= '0;
      r_wdata   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_strobe && !w_busy) begin
        r_pending <= 1'b1;
        r_op_wr   <= i_wr & ~i_rd;
        r_addr    <= i_addr;
        r_width   <= i_width;
        r_wdata   <= i_wdata;
      end else if (i_retire) begin
        r_pending <= 1'b0;
      end
      if ((w_strobe && w_busy) || (i_rd && i_wr))
        r_overrun <= 1'b1;
    end
  end

  always_comb begin
    o_pending = r_pending;
    o_op_wr   = r_op_wr;
    o_addr    = r_addr;
    o_width   = r_width;
    o_wdata   = r_wdata;
    o_overrun = r_overrun;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between the cart bus and the USB
// host path; one transaction at a time, results returned to the owner.
module mem_port_arbiter
  import gba_io_pkg::*;
#(
  parameter bit CART_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cart_rd,
  input  logic              i_cart_wr,
  input  logic [ADDR_W-1:0] i_cart_addr,
  input  logic [1:0]        i_cart_width,
  input  logic [15:0]       i_cart_wr_data,
  output logic [15:0]       o_cart_rd_data,
  output logic              o_cart_rd_valid,
  input  logic              i_usb_rd,
  input  logic              i_usb_wr,
  input  logic [ADDR_W-1:0] i_usb_addr,
  input  logic [31:0]       i_usb_wr_data,
  output logic [31:0]       o_usb_rd_data,
  output logic              o_usb_rd_valid,
  output logic              o_usb_wr_ready,
  output logic              o_from_cart,
  output logic              o_from_usb,
  output logic [ADDR_W-1:0] o_cart_usb_addr,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [1:0]        o_mem_data_width,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wr_data,
  input  logic              i_mem_rd_ready,
  input  logic              i_mem_wr_ready,
  input  logic              i_mem_rd_valid,
  input  logic [31:0]       i_mem_rd_data,
  output logic              o_cart_overrun
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  src_t              r_src;
  src_t              r_last_src;
  src_t              w_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_width;
  logic [31:0]       r_wdata;
  logic [15:0]       r_cart_rd_data;
  logic              r_cart_rd_valid;
  logic [31:0]       r_usb_rd_data;
  logic              r_usb_rd_valid;
  logic              r_usb_wr_ready;
  logic              r_usb_rd_q;
  logic              r_usb_wr_q;
  logic              w_usb_req;
  logic              w_rd_done;
  logic              w_wr_done;
  logic              w_retire;
  logic              w_cart_pending;
  logic              w_cart_op_wr;
  logic [ADDR_W-1:0] w_cart_addr;
  logic [1:0]        w_cart_width;
  logic [15:0]       w_cart_wdata;
  logic              w_cart_overrun;

  cart_req_capture u_cart_cap (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd      (i_cart_rd),
    .i_wr      (i_cart_wr),
    .i_addr    (i_cart_addr),
    .i_width   (i_cart_width),
    .i_wdata   (i_cart_wr_data),
    .i_retire  (w_retire),
    .o_pending (w_cart_pending),
    .o_op_wr   (w_cart_op_wr),
    .o_addr    (w_cart_addr),
    .o_width   (w_cart_width),
    .o_wdata   (w_cart_wdata),
    .o_overrun (w_cart_overrun)
  );

  // USB levels are registered so a cart strobe and a USB request raised in
  // the same cycle reach arbitration together; the completion pulse masks
  // the request the requester is still dropping.
  always_comb begin
    w_usb_req = (r_usb_rd_q | r_usb_wr_q) & ~r_usb_wr_ready & ~r_usb_rd_valid;
    w_rd_done = (r_state == ST_RD_WAIT) & i_mem_rd_valid;
    w_wr_done = (r_state == ST_WR_REQ) & i_mem_wr_ready;
    w_retire  = (w_rd_done | w_wr_done) & (r_src == SRC_CART);
  end

  always_comb begin
    w_sel = SRC_NONE;
    if (r_state == ST_IDLE) begin
      if (w_cart_pending && w_usb_req)
        w_sel = (CART_PRIORITY || r_last_src != SRC_CART) ? SRC_CART : SRC_USB;
      else if (w_cart_pending)
        w_sel = SRC_CART;
      else if (w_usb_req)
        w_sel = SRC_USB;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_sel == SRC_CART)     w_next = w_cart_op_wr ? ST_WR_REQ : ST_RD_REQ;
        else if (w_sel == SRC_USB) w_next = r_usb_rd_q ? ST_RD_REQ : ST_WR_REQ;
      end
      ST_RD_REQ:  if (i_mem_rd_ready) w_next = ST_RD_WAIT;
      ST_RD_WAIT: if (i_mem_rd_valid) w_next = ST_IDLE;
      ST_WR_REQ:  if (i_mem_wr_ready) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src           <= SRC_NONE;
      r_last_src      <= SRC_NONE;
      r_addr          <= '0;
      r_width         <= '0;
      r_wdata         <= '0;
      r_cart_rd_data  <= '0;
      r_cart_rd_valid <= 1'b0;
      r_usb_rd_data   <= '0;
      r_usb_rd_valid  <= 1'b0;
      r_usb_wr_ready  <= 1'b0;
      r_usb_rd_q      <= 1'b0;
      r_usb_wr_q      <= 1'b0;
    end else begin
      r_usb_rd_q      <= i_usb_rd;
      r_usb_wr_q      <= i_usb_wr;
      r_cart_rd_valid <= 1'b0;
      r_usb_rd_valid  <= 1'b0;
      r_usb_wr_ready  <= 1'b0;
      if (w_sel == SRC_CART) begin
        r_src      <= SRC_CART;
        r_last_src <= SRC_CART;
        r_addr     <= w_cart_addr;
        r_width    <= w_cart_width;
        r_wdata    <= cart_wr_word(w_cart_width, w_cart_wdata);
      end else if (w_sel == SRC_USB) begin
        r_src      <= SRC_USB;
        r_last_src <= SRC_USB;
        r_addr     <= i_usb_addr;
        r_width    <= W32;
        r_wdata    <= i_usb_wr_data;
      end
      if (w_rd_done || w_wr_done)
        r_src <= SRC_NONE;
      if (w_rd_done && r_src == SRC_CART) begin
        r_cart_rd_valid <= 1'b1;
        r_cart_rd_data  <= cart_rd_half(r_width, i_mem_rd_data[15:0]);
      end
      if (w_rd_done && r_src == SRC_USB) begin
        r_usb_rd_valid <= 1'b1;
        r_usb_rd_data  <= i_mem_rd_data;
      end
      if (w_wr_done && r_src == SRC_USB)
        r_usb_wr_ready <= 1'b1;
    end
  end

  always_comb begin
    o_mem_rd         = (r_state == ST_RD_REQ);
    o_mem_wr         = (r_state == ST_WR_REQ);
    o_from_cart      = (r_src == SRC_CART);
    o_from_usb       = (r_src == SRC_USB);
    o_cart_usb_addr  = r_addr;
    o_mem_addr       = i_mem_addr;
    o_mem_data_width = r_width;
    o_mem_wr_data    = r_wdata;
    o_cart_rd_data   = r_cart_rd_data;
    o_cart_rd_valid  = r_cart_rd_valid;
    o_usb_rd_data    = r_usb_rd_data;
    o_usb_rd_valid   = r_usb_rd_valid;
    o_usb_wr_ready   = r_usb_wr_ready;
    o_cart_overrun   = w_cart_overrun;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small memory and
// buffer responder; expected values are hand-derived cycle by cycle.
module tb_mem_port_arbiter;
  import gba_io_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cart_rd, i_cart_wr;
  logic [25:0] i_cart_addr;
  logic [1:0]  i_cart_width;
  logic [15:0] i_cart_wr_data;
  logic [15:0] o_cart_rd_data;
  logic        o_cart_rd_valid;
  logic        i_usb_rd, i_usb_wr;
  logic [25:0] i_usb_addr;
  logic [31:0] i_usb_wr_data;
  logic [31:0] o_usb_rd_data;
  logic        o_usb_rd_valid, o_usb_wr_ready;
  logic        o_from_cart, o_from_usb;
  logic [25:0] o_cart_usb_addr, i_mem_addr, o_mem_addr;
  logic        o_mem_rd, o_mem_wr;
  logic [1:0]  o_mem_data_width;
  logic [31:0] o_mem_wr_data;
  logic        i_mem_rd_ready, i_mem_wr_ready, i_mem_rd_valid;
  logic [31:0] i_mem_rd_data;
  logic        o_cart_overrun;

  int n_cmp = 0;
  int n_err = 0;
  int rd_lat = 1;
  int wr_delay = 1;
  int vcnt = 0;
  int wr_cnt = 0;
  int n_rd_hs = 0, n_wr_cyc = 0, n_cart_v = 0, n_usb_v = 0, n_usb_rdy = 0;
  int b_rd_hs, b_wr_cyc, b_cart_v, b_usb_v, b_usb_rdy;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.CART_PRIORITY(1'b1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_cart_rd        (i_cart_rd),
    .i_cart_wr        (i_cart_wr),
    .i_cart_addr      (i_cart_addr),
    .i_cart_width     (i_cart_width),
    .i_cart_wr_data   (i_cart_wr_data),
    .o_cart_rd_data   (o_cart_rd_data),
    .o_cart_rd_valid  (o_cart_rd_valid),
    .i_usb_rd         (i_usb_rd),
    .i_usb_wr         (i_usb_wr),
    .i_usb_addr       (i_usb_addr),
    .i_usb_wr_data    (i_usb_wr_data),
    .o_usb_rd_data    (o_usb_rd_data),
    .o_usb_rd_valid   (o_usb_rd_valid),
    .o_usb_wr_ready   (o_usb_wr_ready),
    .o_from_cart      (o_from_cart),
    .o_from_usb       (o_from_usb),
    .o_cart_usb_addr  (o_cart_usb_addr),
    .i_mem_addr       (i_mem_addr),
    .o_mem_rd         (o_mem_rd),
    .o_mem_wr         (o_mem_wr),
    .o_mem_data_width (o_mem_data_width),
    .o_mem_addr       (o_mem_addr),
    .o_mem_wr_data    (o_mem_wr_data),
    .i_mem_rd_ready   (i_mem_rd_ready),
    .i_mem_wr_ready   (i_mem_wr_ready),
    .i_mem_rd_valid   (i_mem_rd_valid),
    .i_mem_rd_data    (i_mem_rd_data),
    .o_cart_overrun   (o_cart_overrun)
  );

  // Buffer flips the top address bit; memory accepts reads at once and
  // returns data rd_lat cycles later; write ready arrives on the
  // wr_delay-th cycle of mem_wr.
  assign i_mem_addr     = o_cart_usb_addr ^ 26'h2000000;
  assign i_mem_rd_ready = 1'b1;
  assign i_mem_rd_valid = (vcnt == 1);
  assign i_mem_wr_ready = o_mem_wr && (wr_cnt >= wr_delay - 1);
  assign i_mem_rd_data  = mem_rdata;

  always @(posedge clk) begin
    if (o_mem_rd && i_mem_rd_ready) vcnt <= rd_lat;
    else if (vcnt != 0)             vcnt <= vcnt - 1;
    wr_cnt <= o_mem_wr ? wr_cnt + 1 : 0;
  end

  always @(negedge clk) begin
    n_rd_hs   <= n_rd_hs + int'(o_mem_rd && i_mem_rd_ready);
    n_wr_cyc  <= n_wr_cyc + int'(o_mem_wr);
    n_cart_v  <= n_cart_v + int'(o_cart_rd_valid);
    n_usb_v   <= n_usb_v + int'(o_usb_rd_valid);
    n_usb_rdy <= n_usb_rdy + int'(o_usb_wr_ready);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic snap;
    b_rd_hs = n_rd_hs; b_wr_cyc = n_wr_cyc; b_cart_v = n_cart_v;
    b_usb_v = n_usb_v; b_usb_rdy = n_usb_rdy;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got_rdy;
    bit seen_wr;
    rst_n = 1'b0;
    i_cart_rd = 0; i_cart_wr = 0; i_cart_addr = '0; i_cart_width = '0; i_cart_wr_data = '0;
    i_usb_rd = 0; i_usb_wr = 0; i_usb_addr = '0; i_usb_wr_data = '0;
    tick; tick;
    check_eq("rst_mem_rd", o_mem_rd, 0);
    check_eq("rst_mem_wr", o_mem_wr, 0);
    check_eq("rst_from", {o_from_cart, o_from_usb}, 0);
    check_eq("rst_addr", o_cart_usb_addr, 0);
    check_eq("rst_width", o_mem_data_width, 0);
    check_eq("rst_wdata", o_mem_wr_data, 0);
    check_eq("rst_valids", {o_cart_rd_valid, o_usb_rd_valid, o_usb_wr_ready}, 0);
    check_eq("rst_overrun", o_cart_overrun, 0);
    rst_n = 1'b1;
    tick;

    // Cart 16-bit read, zero wait states
    mem_rdata = 32'hDEAD_BEEF; rd_lat = 1;
    i_cart_rd = 1; i_cart_addr = 26'h0000100; i_cart_width = W16;
    tick; i_cart_rd = 0;
    check_eq("t1_c1_mem_rd", o_mem_rd, 0);
    tick;
    check_eq("t1_c2_mem_rd", o_mem_rd, 1);
    check_eq("t1_c2_from", {o_from_cart, o_from_usb}, 2'b10);
    check_eq("t1_c2_width", o_mem_data_width, 2'b10);
    check_eq("t1_c2_cuaddr", o_cart_usb_addr, 26'h0000100);
    check_eq("t1_c2_memaddr", o_mem_addr, 26'h2000100);
    tick;
    check_eq("t1_c3_mem_rd", o_mem_rd, 0);
    check_eq("t1_c3_valid", o_cart_rd_valid, 0);
    tick;
    check_eq("t1_c4_valid", o_cart_rd_valid, 1);
    check_eq("t1_c4_data", o_cart_rd_data, 16'hBEEF);
    tick;
    check_eq("t1_c5_valid", o_cart_rd_valid, 0);
    check_eq("t1_c5_hold", o_cart_rd_data, 16'hBEEF);
    check_eq("t1_c5_from", {o_from_cart, o_from_usb}, 0);

    // Cart 8-bit write
    snap; wr_delay = 1;
    i_cart_wr = 1; i_cart_addr = {1'b1, 9'b0, 16'h0004}; i_cart_width = W8; i_cart_wr_data = 16'hAB5A;
    tick; i_cart_wr = 0;
    check_eq("t2_c1_mem_wr", o_mem_wr, 0);
    tick;
    check_eq("t2_c2_mem_wr", o_mem_wr, 1);
    check_eq("t2_c2_mem_rd", o_mem_rd, 0);
    check_eq("t2_c2_width", o_mem_data_width, 2'b01);
    check_eq("t2_c2_wdata", o_mem_wr_data, 32'h0000_005A);
    check_eq("t2_c2_from", {o_from_cart, o_from_usb}, 2'b10);
    tick;
    check_eq("t2_c3_mem_wr", o_mem_wr, 0);
    repeat (4) tick;
    check_eq("t2_wr_cycles", n_wr_cyc - b_wr_cyc, 1);
    check_eq("t2_no_rd_valid", n_cart_v - b_cart_v, 0);

    // USB write, ready delayed 3 cycles
    snap; wr_delay = 3; got_rdy = 0; seen_wr = 0;
    i_usb_wr = 1; i_usb_addr = 26'h0000040; i_usb_wr_data = 32'h1234_5678;
    for (int i = 0; i < 20 && !got_rdy; i++) begin
      tick;
      if (o_mem_wr && !seen_wr) begin
        seen_wr = 1;
        check_eq("t3_wdata", o_mem_wr_data, 32'h1234_5678);
        check_eq("t3_width", o_mem_data_width, 2'b11);
        check_eq("t3_from", {o_from_cart, o_from_usb}, 2'b01);
      end
      if (o_usb_wr_ready) begin
        got_rdy = 1;
        i_usb_wr = 0;
      end
    end
    check_eq("t3_ready_seen", got_rdy, 1);
    i_usb_wr = 0;
    repeat (6) tick;
    check_eq("t3_wr_cycles", n_wr_cyc - b_wr_cyc, 3);
    check_eq("t3_ready_pulses", n_usb_rdy - b_usb_rdy, 1);

    // Simultaneous cart read and USB read, cart priority
    snap; wr_delay = 1; rd_lat = 1; mem_rdata = 32'h1111_2222;
    i_cart_rd = 1; i_cart_addr = 26'h0000300; i_cart_width = W16;
    i_usb_rd = 1; i_usb_addr = 26'h0000080;
    tick; i_cart_rd = 0;
    check_eq("t4_c1_mem_rd", o_mem_rd, 0);
    tick;
    check_eq("t4_c2_mem_rd", o_mem_rd, 1);
    check_eq("t4_c2_from", {o_from_cart, o_from_usb}, 2'b10);
    check_eq("t4_c2_cuaddr", o_cart_usb_addr, 26'h0000300);
    tick;
    tick;
    check_eq("t4_c4_cart_valid", o_cart_rd_valid, 1);
    check_eq("t4_c4_cart_data", o_cart_rd_data, 16'h2222);
    mem_rdata = 32'hCAFE_F00D;
    tick;
    check_eq("t4_c5_mem_rd", o_mem_rd, 1);
    check_eq("t4_c5_from", {o_from_cart, o_from_usb}, 2'b01);
    check_eq("t4_c5_width", o_mem_data_width, 2'b11);
    check_eq("t4_c5_memaddr", o_mem_addr, 26'h2000080);
    tick;
    tick;
    check_eq("t4_c7_usb_valid", o_usb_rd_valid, 1);
    check_eq("t4_c7_usb_data", o_usb_rd_data, 32'hCAFE_F00D);
    check_eq("t4_c7_cart_hold", o_cart_rd_data, 16'h2222);
    i_usb_rd = 0;
    repeat (5) tick;
    check_eq("t4_rd_handshakes", n_rd_hs - b_rd_hs, 2);
    check_eq("t4_usb_pulses", n_usb_v - b_usb_v, 1);
    check_eq("t4_cart_pulses", n_cart_v - b_cart_v, 1);

    // Strobe while pending: dropped, overrun set
    do_reset;
    check_eq("t5_rst_cart_data", o_cart_rd_data, 0);
    check_eq("t5_rst_usb_data", o_usb_rd_data, 0);
    snap; rd_lat = 3; mem_rdata = 32'h0000_4321;
    i_cart_rd = 1; i_cart_addr = 26'h0000010; i_cart_width = W16;
    tick; i_cart_rd = 0;
    tick;
    tick;
    check_eq("t5_c3_overrun", o_cart_overrun, 0);
    i_cart_rd = 1; i_cart_addr = 26'h0000020;
    tick; i_cart_rd = 0;
    check_eq("t5_c4_overrun", o_cart_overrun, 1);
    tick;
    tick;
    check_eq("t5_c6_valid", o_cart_rd_valid, 1);
    check_eq("t5_c6_data", o_cart_rd_data, 16'h4321);
    repeat (6) tick;
    check_eq("t5_rd_handshakes", n_rd_hs - b_rd_hs, 1);
    check_eq("t5_overrun_sticky", o_cart_overrun, 1);

    // Strobe in the retire cycle is accepted
    do_reset;
    check_eq("t5b_rst_overrun", o_cart_overrun, 0);
    snap; rd_lat = 3; wr_delay = 1;
    i_cart_rd = 1; i_cart_addr = 26'h0000010; i_cart_width = W16;
    tick; i_cart_rd = 0;
    repeat (4) tick;
    i_cart_wr = 1; i_cart_addr = 26'h0000044; i_cart_wr_data = 16'h7777;
    tick; i_cart_wr = 0;
    check_eq("t5b_c6_valid", o_cart_rd_valid, 1);
    check_eq("t5b_c6_overrun", o_cart_overrun, 0);
    tick;
    check_eq("t5b_c7_mem_wr", o_mem_wr, 1);
    check_eq("t5b_c7_wdata", o_mem_wr_data, 32'h0000_7777);
    check_eq("t5b_c7_cuaddr", o_cart_usb_addr, 26'h0000044);
    repeat (4) tick;
    check_eq("t5b_wr_cycles", n_wr_cyc - b_wr_cyc, 1);
    check_eq("t5b_overrun_end", o_cart_overrun, 0);

    // cart_rd and cart_wr together: read plus overrun; 8-bit read return
    do_reset;
    snap; rd_lat = 1; mem_rdata = 32'hAABB_CCDD;
    i_cart_rd = 1; i_cart_wr = 1; i_cart_addr = 26'h0000055; i_cart_width = W8;
    tick; i_cart_rd = 0; i_cart_wr = 0;
    check_eq("t5c_c1_overrun", o_cart_overrun, 1);
    tick;
    check_eq("t5c_c2_rdwr", {o_mem_rd, o_mem_wr}, 2'b10);
    check_eq("t5c_c2_width", o_mem_data_width, 2'b01);
    tick;
    tick;
    check_eq("t5c_c4_valid", o_cart_rd_valid, 1);
    check_eq("t5c_c4_data", o_cart_rd_data, 16'h00DD);
    repeat (3) tick;
    check_eq("t5c_no_write", n_wr_cyc - b_wr_cyc, 0);

    // Reset during USB RD_WAIT
    do_reset;
    snap; rd_lat = 4; mem_rdata = 32'h55AA_55AA;
    i_usb_rd = 1; i_usb_addr = 26'h0000123;
    tick;
    tick;
    check_eq("t6_c2_mem_rd", o_mem_rd, 1);
    check_eq("t6_c2_from", {o_from_cart, o_from_usb}, 2'b01);
    tick;
    check_eq("t6_c3_mem_rd", o_mem_rd, 0);
    check_eq("t6_c3_from", {o_from_cart, o_from_usb}, 2'b01);
    rst_n = 1'b0; i_usb_rd = 0;
    tick;
    check_eq("t6_rst_strobes", {o_mem_rd, o_mem_wr}, 0);
    check_eq("t6_rst_from", {o_from_cart, o_from_usb}, 0);
    check_eq("t6_rst_cuaddr", o_cart_usb_addr, 0);
    check_eq("t6_rst_width", o_mem_data_width, 0);
    check_eq("t6_rst_valids", {o_cart_rd_valid, o_usb_rd_valid, o_usb_wr_ready}, 0);
    rst_n = 1'b1;
    repeat (8) tick;
    check_eq("t6_late_valid_ignored", n_usb_v - b_usb_v, 0);
    check_eq("t6_rd_handshakes", n_rd_hs - b_rd_hs, 1);
    check_eq("t6_usb_data", o_usb_rd_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the single external memory port between the GBA cartridge bus and the USB host path. Sits at the mux position: it owns the mux side of the cart, USB, buffer and memory interfaces. It captures single-cycle cart strobes, holds level USB requests, and routes address translation through the buffer. It runs one memory transaction at a time and returns read data and completions to the originating side.

## Interface
- CART_PRIORITY, 1: 1 = a pending cart request wins over a waiting USB request; 0 = strict alternation when both wait.
- clk  input  1  single clock for all logic
- rst_n  input  1  reset; synchronous, active-low
- cart  modport  cart_mux_interface.mux  cart strobes/data in; cart_rd_data, cart_rd_valid out
- usb  modport  mux_usb_interface.mux  USB level requests in; usb_rd_data, usb_rd_valid, usb_wr_ready out
- buf_if  modport  mux_buffer_interface.mux  from_cart/from_usb/cart_usb_addr out; translated mem_addr in
- mem  modport  mux_mem_interface.mux  memory strobes/width/address/write data out; ready/valid/read data in
- cart_overrun  output  1  sticky; set when a cart strobe arrives while one is already pending; cleared only by reset

## Operation
- Cart capture: a cart_rd or cart_wr pulse loads a one-deep pending register with op, addr, width and wr_data. A strobe in the same cycle the pending entry retires is accepted. cart_rd and cart_wr together: treat as a read and set cart_overrun. A strobe while pending: drop it and set cart_overrun.
- USB requests are levels: usb_rd is held until usb_rd_valid; usb_wr is held until usb_wr_ready. usb_rd and usb_wr together: the read is served first.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- IDLE: pick a source (cart first when CART_PRIORITY=1). On selection, register from_cart/from_usb one-hot and cart_usb_addr; go to RD_REQ or WR_REQ.
- RD_REQ: assert mem_rd. On mem_rd & mem_rd_ready, go to RD_WAIT.
- RD_WAIT: on mem_rd_valid, return data to the owner and go to IDLE.
- WR_REQ: assert mem_wr. On mem_wr & mem_wr_ready, retire the request. For USB, pulse usb_wr_ready for 1 cycle. Go to IDLE.
- mem_addr comes from buf_if.mem_addr, combinational from the registered cart_usb_addr.
- mem_data_width: the cart width (01 or 10) for cart; 11 for USB.
- mem_wr_data: cart 16-bit uses {16'h0, wr_data}; cart 8-bit uses {24'h0, wr_data[7:0]}; USB passes all 32 bits.
- Cart read return: 16-bit returns mem_rd_data[15:0]; 8-bit returns {8'h0, mem_rd_data[7:0]}. USB read returns all 32 bits.
- A granted transaction always completes; there is no preemption.
- debug_mem_rd_data is ignored.

## Timing
- Reset (clk edge with rst_n=0): state IDLE, pending cleared, cart_overrun=0. All outputs are 0: strobes, valids, ready, from_cart/from_usb, cart_usb_addr, data and width. Any in-flight transaction is abandoned; mem_rd/mem_wr are low from the next cycle.
- mem_rd, mem_wr, from_* and width are registered, Moore-decoded from state.
- Cart read, zero wait states:
  - cycle 0: cart_rd strobe.
  - cycle 1: pending set; IDLE selects the cart.
  - cycle 2: mem_rd high.
  - cycle 3: earliest mem_rd_valid.
  - cycle 4: cart_rd_valid high.
- cart_rd_valid and usb_rd_valid are 1-cycle registered pulses, the cycle after mem_rd_valid. Read data holds until the next read completes.
- usb_wr_ready: a 1-cycle pulse, the cycle after the mem write handshake.
- After a completion, the FSM spends at least 1 cycle in IDLE before the next grant.
- With CART_PRIORITY=1, a continuously pending cart can starve USB; this is accepted.

## Structure
- Shared package gba_io_pkg:
  - width constants W8=2'b01, W16=2'b10, W32=2'b11;
  - arbiter state enum;
  - source enum (SRC_NONE, SRC_CART, SRC_USB).
- Sub-module cart_req_capture: the one-deep pending register plus overrun detection. Its outputs are pending, op, addr, width and wdata; its input is the retire pulse.

## Test plan
- Cart 16-bit read of addr 26'h0000100; mem returns 32'hDEAD_BEEF with zero waits -> mem_data_width=10; cart_rd_valid in cycle 4 with 16'hBEEF.
- Cart 8-bit write of 8'h5A to addr {1'b1,9'b0,16'h0004} -> mem_wr with width 01 and mem_wr_data=32'h0000005A; no cart_rd_valid.
- USB write of 32'h1234_5678 with mem_wr_ready delayed 3 cycles -> mem_wr held 3 cycles; one usb_wr_ready pulse; usb_wr deasserted, then no second write.
- USB read and cart read in the same cycle, CART_PRIORITY=1 -> cart completes first, then USB; from_cart/from_usb one-hot in each; usb_rd_valid carries the full 32 bits.
- Second cart_rd while the first is in RD_WAIT -> cart_overrun=1, only one mem_rd issued. A strobe in the retire cycle is accepted without overrun.
- rst_n low during USB RD_WAIT -> next cycle all outputs 0 and state IDLE; a late mem_rd_valid produces no usb_rd_valid.
